// File: rtl/serial_subtractor12.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, one bit per clock,
// with valid/ready handshakes on input and output.
module serial_subtractor12 #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] sd;
  logic [WIDTH-1:0] sd_nx;
  logic             br, br_nx, d, last;
  logic [CW-1:0]    cnt;

  // Single full-subtractor cell working on the current LSB of the operand registers
  always_comb begin
    d     = sa[0] ^ sb[0] ^ br;
    br_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    sd_nx = {d, sd};
    last  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result fields are only written on the final bit, so they hold steadily in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_nx[WIDTH-1:1];
          br  <= br_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= sd_nx;
            bout <= br_nx;
            ovf  <= br ^ br_nx;
            zero <= (sd_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor12.sv
// Directed self-checking bench for serial_subtractor12 (WIDTH=12).
module tb_serial_subtractor12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] diff;
  logic        bout, zero, ovf;

  int checks = 0;
  int errors = 0;

  serial_subtractor12 #(.WIDTH(12), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Accept one operation and return cycles from accept edge to out_valid (99 on timeout)
  task automatic start_op(input logic [11:0] ta, input logic [11:0] tb, input logic tbin,
                          output int lat);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 12'hABC; b = 12'h321; bin = 1'b1;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, diff, bout, zero, ovf} !== {1'b1, 1'b0, 12'h000, 3'b000}) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b diff=%h b=%b z=%b o=%b, want 1 0 000 0 0 0",
               in_ready, out_valid, diff, bout, zero, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vec(input string name, input logic [11:0] ta, input logic [11:0] tb,
                          input logic tbin, input logic [11:0] ed, input logic eb,
                          input logic ez, input logic eo);
    int lat;
    start_op(ta, tb, tbin, lat);
    checks++;
    if (lat !== 12) begin
      errors++;
      $display("FAIL %s latency: got %0d want 12", name, lat);
    end
    checks++;
    if ({diff, bout, zero, ovf} !== {ed, eb, ez, eo}) begin
      errors++;
      $display("FAIL %s result: got diff=%h b=%b z=%b o=%b want diff=%h b=%b z=%b o=%b",
               name, diff, bout, zero, ovf, ed, eb, ez, eo);
    end
    release_result();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s release: got vld=%b rdy=%b want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(12'h123, 12'h023, 1'b0, lat);
    checks++;
    if (lat !== 12) begin
      errors++;
      $display("FAIL bp latency: got %0d want 12", lat);
    end
    // New operands waiting while the result is held must not be taken
    a = 12'h00A; b = 12'h003; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, diff, bout, zero, ovf} !== {2'b10, 12'h100, 3'b000}) begin
        errors++;
        $display("FAIL bp hold %0d: got vld=%b rdy=%b diff=%h b=%b z=%b o=%b want 1 0 100 0 0 0",
                 i, out_valid, in_ready, diff, bout, zero, ovf);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp accept: got rdy=%b want 0", in_ready);
    end
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    checks++;
    if (lat !== 12 || diff !== 12'h007 || bout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL bp second op: got lat=%0d diff=%h b=%b z=%b o=%b want 12 007 0 0 0",
               lat, diff, bout, zero, ovf);
    end
    release_result();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    a = 12'hFFF; b = 12'h001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({in_ready, out_valid, diff, bout, zero, ovf} !== {1'b1, 1'b0, 12'h000, 3'b000}) begin
      errors++;
      $display("FAIL midreset: got rdy=%b vld=%b diff=%h b=%b z=%b o=%b want 1 0 000 0 0 0",
               in_ready, out_valid, diff, bout, zero, ovf);
    end
    start_op(12'h002, 12'h001, 1'b0, lat);
    checks++;
    if (lat !== 12 || diff !== 12'h001 || bout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midreset new op: got lat=%0d diff=%h b=%b z=%b o=%b want 12 001 0 0 0",
               lat, diff, bout, zero, ovf);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_vec("basic",     12'h123, 12'h023, 1'b0, 12'h100, 1'b0, 1'b0, 1'b0);
    test_vec("underflow", 12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0);
    test_vec("sovf",      12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b0, 1'b1);
    test_vec("zero_bin",  12'h010, 12'h00F, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0);
    test_vec("zero_eq",   12'h555, 12'h555, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    test_vec("negovf",    12'h7FF, 12'hFFF, 1'b0, 12'h800, 1'b1, 1'b0, 1'b1);
    test_backpressure();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
